// File: rtl/gimli_lwc_buffer_in.sv
// gimli_lwc_buffer_in
// Packs a stream of G_WIDTH-bit words into 4-word blocks for the Gimli LWC core.
// A block is presented when it holds four words or when the message ends early.
// Unwritten word slots read as zero. Each presented block carries its word count
// and an end-of-message flag. A new word can be accepted in the same cycle that
// the held block is released, so back-to-back traffic runs without bubbles.
module gimli_lwc_buffer_in #(
    parameter int G_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [G_WIDTH-1:0]     din,
    input  logic                   din_last,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [4*G_WIDTH-1:0]   dout,
    output logic [2:0]             dout_size,
    output logic                   dout_last,
    output logic                   dout_valid,
    input  logic                   dout_ready
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           count_q, count_d;
    logic [4*G_WIDTH-1:0] data_q,  data_d;
    logic                 last_q,  last_d;
    logic                 accept;

    // Handshake: always ready while filling. While full, a slot only frees up when the consumer takes the block.
    assign din_ready = (state_q == FILL) || dout_ready;
    assign accept    = din_valid && din_ready;

    // Next-state and block assembly
    always_comb begin
        // NOTE: every variable written here takes its default first. Any path that
        // leaves a variable unassigned would otherwise infer a latch.
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        last_d  = last_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < 4; k++) begin
                        if (count_q[1:0] == 2'(k)) begin
                            data_d[k*G_WIDTH +: G_WIDTH] = din;
                        end
                    end
                    count_d = count_q + 3'd1;
                    if (count_q == 3'd3 || din_last) begin
                        state_d = FULL;
                        last_d  = din_last;
                    end
                end
            end
            FULL: begin
                if (dout_ready) begin
                    // The consumer takes the block. Start again from an all-zero block.
                    state_d = FILL;
                    count_d = 3'd0;
                    data_d  = '0;
                    last_d  = 1'b0;
                    if (din_valid) begin
                        // A word arriving in the same cycle goes into slot 0 of the fresh block.
                        data_d[G_WIDTH-1:0] = din;
                        count_d             = 3'd1;
                        if (din_last) begin
                            state_d = FULL;
                            last_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: the data register is included in the reset. A discarded block
        // must read as zero, not as stale words.
        if (rst) begin
            state_q <= FILL;
            count_q <= 3'd0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. All
            // flops therefore update together from the values present before the edge.
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign dout       = data_q;
    assign dout_valid = (state_q == FULL);
    assign dout_size  = (state_q == FULL) ? count_q : 3'd0;
    assign dout_last  = last_q;

endmodule

// File: tb/tb_gimli_lwc_buffer_in.sv
// Testbench for gimli_lwc_buffer_in.
// Directed scenarios carry literal expectations. A free-running monitor compares the
// DUT on every cycle against a word/block queue model of the packing rules.
module tb_gimli_lwc_buffer_in;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   din;
    logic           din_last;
    logic           din_valid;
    logic           din_ready;
    logic [4*W-1:0] dout;
    logic [2:0]     dout_size;
    logic           dout_last;
    logic           dout_valid;
    logic           dout_ready;

    int n_checks = 0;
    int n_pass   = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [4*W-1:0] data;
        logic [2:0]     size;
        logic           last;
    } blk_t;

    blk_t       exp_q[$];
    logic [W-1:0] cur[$];

    always #5 clk = ~clk;

    gimli_lwc_buffer_in #(.G_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_last   (din_last),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_size  (dout_size),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    task automatic check(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the edge that sampled them.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        din_valid  = v;
        din        = d;
        din_last   = l;
        dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Reference model and per-cycle comparison, evaluated mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_valid;
            exp_valid = (exp_q.size() != 0);
            check("mon_dout_valid", dout_valid, exp_valid);
            check("mon_din_ready", din_ready, !exp_valid || dout_ready);
            if (exp_valid) begin
                check("mon_dout", dout, exp_q[0].data);
                check("mon_dout_size", dout_size, exp_q[0].size);
                check("mon_dout_last", dout_last, exp_q[0].last);
            end else begin
                check("mon_idle_size", dout_size, 3'd0);
                check("mon_idle_last", dout_last, 1'b0);
                if (cur.size() == 0) check("mon_idle_dout_zero", dout, '0);
            end

            if (rst) begin
                exp_q.delete();
                cur.delete();
            end else begin
                if (exp_valid && dout_ready) void'(exp_q.pop_front());
                if (din_valid && (!exp_valid || dout_ready)) begin
                    cur.push_back(din);
                    if (cur.size() == 4 || din_last) begin
                        blk_t b;
                        b.data = '0;
                        for (int i = 0; i < cur.size(); i++) b.data[i*W +: W] = cur[i];
                        b.size = 3'(cur.size());
                        b.last = din_last;
                        exp_q.push_back(b);
                        cur.delete();
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        din = '0; din_last = 1'b0; din_valid = 1'b1; dout_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        din_valid = 1'b0;
        mon_en = 1'b1;
        #1;

        // Reset state
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_dout", dout, '0);
        check("rst_dout_size", dout_size, 3'd0);
        check("rst_dout_last", dout_last, 1'b0);
        check("rst_din_ready", din_ready, 1'b1);

        // Four words, last on the 4th
        cyc(1'b1, 32'h11111111, 1'b0, 1'b1);
        cyc(1'b1, 32'h22222222, 1'b0, 1'b1);
        cyc(1'b1, 32'h33333333, 1'b0, 1'b1);
        check("four_not_yet_valid", dout_valid, 1'b0);
        cyc(1'b1, 32'h44444444, 1'b1, 1'b1);
        check("four_valid", dout_valid, 1'b1);
        check("four_dout", dout, 128'h44444444_33333333_22222222_11111111);
        check("four_size", dout_size, 3'd4);
        check("four_last", dout_last, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("release_valid", dout_valid, 1'b0);
        check("release_dout_zero", dout, '0);

        // Six words, last on the 6th: a full block followed by a 2-word block
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 32'hA0000000 + 32'(i), (i == 5), 1'b1);
            if (i == 3) begin
                check("six_b1_dout", dout, 128'hA0000003_A0000002_A0000001_A0000000);
                check("six_b1_size", dout_size, 3'd4);
                check("six_b1_last", dout_last, 1'b0);
            end
        end
        check("six_b2_valid", dout_valid, 1'b1);
        check("six_b2_dout", dout, 128'h00000000_00000000_A0000005_A0000004);
        check("six_b2_size", dout_size, 3'd2);
        check("six_b2_last", dout_last, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Back-pressure while full, then a simultaneous release and accept
        cyc(1'b1, 32'h0B000001, 1'b0, 1'b0);
        cyc(1'b1, 32'h0B000002, 1'b0, 1'b0);
        cyc(1'b1, 32'h0B000003, 1'b0, 1'b0);
        cyc(1'b1, 32'h0B000004, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h0000BEEF, 1'b0, 1'b0);
            check("stall_din_ready", din_ready, 1'b0);
            check("stall_dout", dout, 128'h0B000004_0B000003_0B000002_0B000001);
            check("stall_size", dout_size, 3'd4);
        end
        dout_ready = 1'b1;
        #1;
        check("unstall_din_ready", din_ready, 1'b1);
        @(posedge clk); #1;
        check("unstall_valid", dout_valid, 1'b0);
        check("unstall_word0", dout, 128'h00000000_00000000_00000000_0000BEEF);
        cyc(1'b1, 32'h0000C001, 1'b1, 1'b1);
        check("unstall_b_size", dout_size, 3'd2);
        check("unstall_b_dout", dout, 128'h00000000_00000000_0000C001_0000BEEF);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Back-to-back single-word messages
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 32'h0D000000 + 32'(i), 1'b1, 1'b1);
            check("b2b_valid", dout_valid, 1'b1);
            check("b2b_size", dout_size, 3'd1);
            check("b2b_last", dout_last, 1'b1);
            check("b2b_dout", dout, {96'h0, 32'h0D000000 + 32'(i)});
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("b2b_end_valid", dout_valid, 1'b0);

        // Reset after two accepted words discards them
        cyc(1'b1, 32'h0E000000, 1'b0, 1'b1);
        cyc(1'b1, 32'h0E000001, 1'b0, 1'b1);
        rst = 1'b1;
        cyc(1'b1, 32'h0E000002, 1'b1, 1'b1);
        rst = 1'b0;
        din_valid = 1'b0;
        #1;
        check("midrst_valid", dout_valid, 1'b0);
        check("midrst_dout", dout, '0);
        check("midrst_din_ready", din_ready, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h0F000000 + 32'(i), (i == 3), 1'b1);
        check("postrst_dout", dout, 128'h0F000003_0F000002_0F000001_0F000000);
        check("postrst_size", dout_size, 3'd4);

        // Reset while a block is held
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("held_valid", dout_valid, 1'b1);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        check("fullrst_valid", dout_valid, 1'b0);
        check("fullrst_size", dout_size, 3'd0);
        check("fullrst_dout", dout, '0);

        // Random stalls and message lengths, checked by the monitor
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            cyc(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 2) != 0));
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1);
        check("drain_no_pending_block", 128'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
